demux_o5_reg: RTL and testbench
===============================

DEMUX_O5_REG -- requirements
Module: demux_o5_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32; width of the data path.
REQ-002 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  upstream word present.
REQ-005 i_select  input  3  destination channel index, 0..4 legal.
REQ-006 i_data  input  DATA_WIDTH  upstream word.
REQ-007 o_ready  output  1  upstream word accepted this cycle when high together with i_valid.
REQ-008 o_valid  output  5  bit k high when channel k holds a word.
REQ-009 i_ready  input  5  bit k high when channel k's consumer takes the held word.
REQ-010 o_data0..o_data4  output  DATA_WIDTH each  held word of channel 0..4.
REQ-011 o_err  output  1  one-cycle pulse when a word with an illegal select is dropped.
REQ-012 o_drop_cnt  output  8  saturating count of dropped words.

Function
REQ-013 Each channel k SHALL hold a one-entry register with a full flag that drives o_valid[k].
REQ-014 Channel k drains when o_valid[k] and i_ready[k] are both high at a rising edge; the full flag then clears unless the channel is refilled in the same cycle.
REQ-015 For i_select 0..4, o_ready SHALL be combinationally high when the selected channel is empty or drains in the current cycle, and low otherwise.
REQ-016 For i_select 5..7, o_ready SHALL be high regardless of channel state.
REQ-017 Accept = i_valid & o_ready; on accept with a legal select, the selected channel's register SHALL load i_data and set its full flag at that edge; visible latency is 1 cycle.
REQ-018 When a channel drains and is refilled in the same cycle, its full flag SHALL stay set and its register SHALL load the new word (no bubble).
REQ-019 An accepted word SHALL never be written to any channel other than the one selected, and SHALL never overwrite a full, non-draining channel.
REQ-020 Channels SHALL be independent: draining any channel SHALL not depend on i_valid, i_select or the state of any other channel.
REQ-021 o_data k SHALL hold its last loaded value after draining; it changes only on a load.
REQ-022 On accept with an illegal select (5..7), the word SHALL be discarded, o_err SHALL be high for exactly the following cycle, and o_drop_cnt SHALL increment by 1.
REQ-023 o_drop_cnt SHALL saturate at 255 and never wrap; o_err still pulses at saturation.
REQ-024 With i_valid low, o_ready is don't-care for upstream, and no channel loads, o_err stays low and o_drop_cnt holds.
REQ-025 With a legal select to a full, non-draining channel, upstream SHALL stall (o_ready low) and i_data/i_select are sampled only on the accepting edge.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately, without a clock, clear all full flags (o_valid = 5'b00000), all o_data0..4 to 0, o_err to 0, and o_drop_cnt to 0.
REQ-027 Reset asserted mid-operation SHALL discard all held words with no partial transfer; the first accept is allowed on the first rising edge after i_rst_n returns high.

Verification
REQ-028 After reset, i_valid=1, i_select=2, i_data=32'hDEADBEEF, i_ready=0 -> o_ready=1; after the next edge, o_valid=5'b00100, o_data2=32'hDEADBEEF, and the other outputs remain 0.
REQ-029 Channel 2 full, i_ready[2]=0, i_valid=1, i_select=2 -> o_ready=0 for as long as this holds; raise i_ready[2] with i_data=32'h00000001 -> o_ready=1, and after the edge o_valid[2] stays 1 and o_data2=32'h00000001.
REQ-030 Channel 2 full and stalled while i_select=4, i_valid=1 -> o_ready=1, and after the edge o_valid=5'b10100 with channel 2's content unchanged.
REQ-031 i_valid=1, i_select=6 for 260 consecutive cycles -> o_err high on each following cycle, o_drop_cnt ends at 255, and o_valid is unchanged.
REQ-032 Load all five channels with values 1..5, then pulse i_rst_n low between clock edges -> o_valid=0, all o_data*=0, and o_drop_cnt=0 immediately, before the next edge.
REQ-033 With all channels full, a single cycle with i_ready=5'b11111 and i_valid=0 -> o_valid=5'b00000 after the edge, and o_data0..4 still read 1..5.

Source files
------------

// File: rtl/demux_o5_reg.sv
// One-to-five registered demultiplexer: each output channel is a one-entry
// skid-free holding register; illegal selects are dropped and counted.
module demux_o5_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [2:0]            i_select,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [4:0]            o_valid,
  input  logic [4:0]            i_ready,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic [DATA_WIDTH-1:0] o_data3,
  output logic [DATA_WIDTH-1:0] o_data4,
  output logic                  o_err,
  output logic [7:0]            o_drop_cnt
);

  localparam int NCH = 5;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is sampled only then.

  logic [NCH-1:0]        full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q [NCH];
  logic [DATA_WIDTH-1:0] data_d [NCH];
  logic                  err_q, err_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic                  sel_legal;
  logic                  sel_free;
  logic                  accept;
  logic [NCH-1:0]        drain;
  logic [NCH-1:0]        load;

  always_comb begin
    sel_legal = (i_select <= 3'd4);
    drain     = full_q & i_ready;
    sel_free  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (sel_legal && (i_select == 3'(k))) begin
        sel_free = ~full_q[k] | i_ready[k];
      end
    end
    o_ready = sel_free;
    accept  = i_valid & sel_free;

    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k]   = accept & sel_legal & (i_select == 3'(k));
      data_d[k] = load[k] ? i_data : data_q[k];
    end
    // A refill in the drain cycle keeps the flag set, so there is no bubble.
    full_d = (full_q & ~drain) | load;

    err_d      = accept & ~sel_legal;
    drop_cnt_d = drop_cnt_q;
    if (err_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q     <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q     <= full_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_valid    = full_q;
  assign o_err      = err_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_data0    = data_q[0];
  assign o_data1    = data_q[1];
  assign o_data2    = data_q[2];
  assign o_data3    = data_q[3];
  assign o_data4    = data_q[4];

endmodule

// File: tb/tb_demux_o5_reg.sv
// Directed self-checking bench for demux_o5_reg: stall, refill, drop
// saturation, drain-all and asynchronous reset scenarios.
module tb_demux_o5_reg;

  localparam int W = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic [2:0]    i_select;
  logic [W-1:0]  i_data;
  logic          o_ready;
  logic [4:0]    o_valid;
  logic [4:0]    i_ready;
  logic [W-1:0]  o_data0, o_data1, o_data2, o_data3, o_data4;
  logic          o_err;
  logic [7:0]    o_drop_cnt;

  int checks;
  int failures;

  demux_o5_reg #(.DATA_WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_select   (i_select),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data0    (o_data0),
    .o_data1    (o_data1),
    .o_data2    (o_data2),
    .o_data3    (o_data3),
    .o_data4    (o_data4),
    .o_err      (o_err),
    .o_drop_cnt (o_drop_cnt)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] data_of(input int k);
    case (k)
      0: data_of = o_data0;
      1: data_of = o_data1;
      2: data_of = o_data2;
      3: data_of = o_data3;
      default: data_of = o_data4;
    endcase
  endfunction

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_select = 3'd0;
    i_data   = '0;
    i_ready  = 5'b0;
    #2;
    checks++;
    if ({o_valid, o_err, o_drop_cnt} !== 14'd0) begin
      failures++;
      $display("FAIL reset_ctrl: valid=%b err=%b drop=%0d, expected 0/0/0", o_valid, o_err, o_drop_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (data_of(k) !== '0) begin
        failures++;
        $display("FAIL reset_data%0d: got %h expected 0", k, data_of(k));
      end
    end
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    i_valid  = 1'b1;
    i_select = 3'd2;
    i_data   = 32'hDEADBEEF;
    i_ready  = 5'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready: got %b expected 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 5'b00100 || o_data2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_ch2: valid=%b data2=%h expected 00100/deadbeef", o_valid, o_data2);
    end
    checks++;
    if ({o_data0, o_data1, o_data3, o_data4} !== '0 || o_err !== 1'b0 || o_drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL load_others: d0=%h d1=%h d3=%h d4=%h err=%b drop=%0d expected all 0",
               o_data0, o_data1, o_data3, o_data4, o_err, o_drop_cnt);
    end
  endtask

  task automatic test_stall_and_refill();
    i_valid  = 1'b1;
    i_select = 3'd2;
    i_data   = 32'hAAAA5555;
    i_ready  = 5'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready cycle %0d: got %b expected 0", c, o_ready);
      end
      tick();
      checks++;
      if (o_data2 !== 32'hDEADBEEF || o_valid !== 5'b00100) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: data2=%h valid=%b expected deadbeef/00100", c, o_data2, o_valid);
      end
    end
    i_ready = 5'b00100;
    i_data  = 32'h00000001;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL refill_ready: got %b expected 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    i_ready = 5'b0;
    checks++;
    if (o_valid !== 5'b00100 || o_data2 !== 32'h00000001) begin
      failures++;
      $display("FAIL refill_ch2: valid=%b data2=%h expected 00100/00000001", o_valid, o_data2);
    end
  endtask

  task automatic test_independent();
    i_valid  = 1'b1;
    i_select = 3'd4;
    i_data   = 32'h44444444;
    i_ready  = 5'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready: got %b expected 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 5'b10100 || o_data2 !== 32'h00000001 || o_data4 !== 32'h44444444) begin
      failures++;
      $display("FAIL indep_ch4: valid=%b d2=%h d4=%h expected 10100/00000001/44444444",
               o_valid, o_data2, o_data4);
    end
  endtask

  task automatic test_illegal_drop();
    int exp_cnt;
    exp_cnt  = 0;
    i_valid  = 1'b1;
    i_select = 3'd6;
    i_data   = 32'hBAD0BAD0;
    i_ready  = 5'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_ready: got %b expected 1", o_ready);
    end
    for (int c = 0; c < 260; c++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      checks++;
      if (o_err !== 1'b1 || o_drop_cnt !== 8'(exp_cnt) || o_valid !== 5'b10100) begin
        failures++;
        $display("FAIL drop_cycle %0d: err=%b drop=%0d valid=%b expected 1/%0d/10100",
                 c, o_err, o_drop_cnt, o_valid, exp_cnt);
      end
    end
    i_valid = 1'b0;
    tick();
    checks++;
    if (o_err !== 1'b0 || o_drop_cnt !== 8'd255 || o_data2 !== 32'h00000001 || o_data4 !== 32'h44444444) begin
      failures++;
      $display("FAIL drop_idle: err=%b drop=%0d d2=%h d4=%h expected 0/255/00000001/44444444",
               o_err, o_drop_cnt, o_data2, o_data4);
    end
  endtask

  task automatic load_all();
    i_ready = 5'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid  = 1'b1;
      i_select = 3'(k);
      i_data   = 32'(k + 1);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL loadall_ready ch%0d: got %b expected 1", k, o_ready);
      end
      tick();
    end
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 5'b11111) begin
      failures++;
      $display("FAIL loadall_valid: got %b expected 11111", o_valid);
    end
  endtask

  task automatic test_drain_all();
    // Drain channels 2 and 4 first; held data must survive the drain.
    i_valid = 1'b0;
    i_ready = 5'b11111;
    tick();
    i_ready = 5'b0;
    checks++;
    if (o_valid !== 5'b00000 || o_data2 !== 32'h00000001 || o_data4 !== 32'h44444444) begin
      failures++;
      $display("FAIL drain_partial: valid=%b d2=%h d4=%h expected 00000/00000001/44444444",
               o_valid, o_data2, o_data4);
    end
    load_all();
    i_ready = 5'b11111;
    tick();
    i_ready = 5'b0;
    checks++;
    if (o_valid !== 5'b00000) begin
      failures++;
      $display("FAIL drain_all_valid: got %b expected 00000", o_valid);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (data_of(k) !== 32'(k + 1)) begin
        failures++;
        $display("FAIL drain_all_data%0d: got %h expected %h", k, data_of(k), 32'(k + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Channel 1 drained and refilled every cycle: valid must never drop.
    i_ready  = 5'b00010;
    i_valid  = 1'b1;
    i_select = 3'd1;
    for (int c = 0; c < 4; c++) begin
      i_data = 32'h100 + 32'(c);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d: got %b expected 1", c, o_ready);
      end
      tick();
      checks++;
      if (o_valid !== 5'b00010 || o_data1 !== 32'h100 + 32'(c)) begin
        failures++;
        $display("FAIL b2b_cycle %0d: valid=%b d1=%h expected 00010/%h", c, o_valid, o_data1, 32'h100 + 32'(c));
      end
    end
    i_valid = 1'b0;
    tick();
    i_ready = 5'b0;
    checks++;
    if (o_valid !== 5'b00000 || o_data1 !== 32'h103) begin
      failures++;
      $display("FAIL b2b_final: valid=%b d1=%h expected 00000/00000103", o_valid, o_data1);
    end
  endtask

  task automatic test_async_reset();
    load_all();
    // Pulse reset between edges; outputs must clear before any clock.
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 5'b0 || o_drop_cnt !== 8'd0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL areset_ctrl: valid=%b drop=%0d err=%b expected 0/0/0", o_valid, o_drop_cnt, o_err);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (data_of(k) !== '0) begin
        failures++;
        $display("FAIL areset_data%0d: got %h expected 0", k, data_of(k));
      end
    end
    i_valid  = 1'b1;
    i_select = 3'd0;
    i_data   = 32'h77;
    #1;
    i_rst_n = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 5'b00001 || o_data0 !== 32'h77) begin
      failures++;
      $display("FAIL areset_first_accept: valid=%b d0=%h expected 00001/00000077", o_valid, o_data0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_load();
    test_stall_and_refill();
    test_independent();
    test_illegal_drop();
    test_drain_all();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
